// File: rtl/apb_slave.sv
// APB register-file slave: DEPTH x DATA_WIDTH registers with an error response for out-of-range addresses.
// Optional wait-state insertion is enabled by defining SLAVE_WAIT_EN (WAIT_STATES extra access cycles).
module apb_slave #(
    parameter int ADDR_WIDTH  = 8,
    parameter int DATA_WIDTH  = 8,
    parameter int DEPTH       = 16,
    parameter int WAIT_STATES = 2
) (
    input  logic                  pclk,
    input  logic                  prst_n,
    input  logic                  pselx,
    input  logic                  penable,
    input  logic                  pwrite,
    input  logic [ADDR_WIDTH-1:0] paddr,
    input  logic [DATA_WIDTH-1:0] pwdata,
    output logic [DATA_WIDTH-1:0] prdata,
    output logic                  pready,
    output logic                  pslverr
);

    localparam int IDX_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CMP_W = (ADDR_WIDTH > 32) ? ADDR_WIDTH + 1 : 33;

    typedef enum logic [1:0] {
        IDLE,
        ACCESS
`ifdef SLAVE_WAIT_EN
        , WAIT
`endif
    } state_e;

    state_e                state_q, state_d;
    logic [DATA_WIDTH-1:0] regs_q [DEPTH];
    logic [DATA_WIDTH-1:0] regs_d [DEPTH];
`ifdef SLAVE_WAIT_EN
    logic [3:0]            cnt_q, cnt_d;
`endif

    logic             complete;
    logic             addr_ok;
    logic [IDX_W-1:0] idx;

    // Full-width unsigned compare: an address never aliases onto a legal register.
    assign addr_ok = CMP_W'(paddr) < CMP_W'(DEPTH);
    assign idx     = IDX_W'(paddr);

    // NOTE: every signal written here gets a default first, so no path leaves it unassigned and no latch is inferred.
    always_comb begin
        state_d  = state_q;
        regs_d   = regs_q;
        complete = 1'b0;
        prdata   = '0;
        pready   = 1'b0;
        pslverr  = 1'b0;
`ifdef SLAVE_WAIT_EN
        cnt_d    = cnt_q;
`endif

        case (state_q)
            IDLE: begin
                if (pselx && !penable) begin
                    state_d = ACCESS;
`ifdef SLAVE_WAIT_EN
                    cnt_d   = 4'(WAIT_STATES);
`endif
                end
            end
            ACCESS: begin
                if (!pselx) begin
                    state_d = IDLE;
                end else if (penable) begin
`ifdef SLAVE_WAIT_EN
                    // This cycle already counts as one wait, so WAIT is only entered for the remainder.
                    if (cnt_q != 4'd0) begin
                        cnt_d   = cnt_q - 4'd1;
                        state_d = (cnt_q == 4'd1) ? ACCESS : WAIT;
                    end else begin
                        complete = 1'b1;
                    end
`else
                    complete = 1'b1;
`endif
                end
            end
`ifdef SLAVE_WAIT_EN
            WAIT: begin
                if (!pselx) begin
                    state_d = IDLE;
                end else if (penable) begin
                    cnt_d = (cnt_q != 4'd0) ? cnt_q - 4'd1 : 4'd0;
                    if (cnt_q <= 4'd1) begin
                        state_d = ACCESS;
                    end
                end
            end
`endif
            default: state_d = IDLE;
        endcase

        if (complete) begin
            state_d = IDLE;
            pready  = 1'b1;
            if (!addr_ok) begin
                pslverr = 1'b1;
            end else if (pwrite) begin
                regs_d[idx] = pwdata;
            end else begin
                prdata = regs_q[idx];
            end
        end

        // Outputs stay quiet while reset is held, whatever state the flops hold.
        if (!prst_n) begin
            prdata  = '0;
            pready  = 1'b0;
            pslverr = 1'b0;
        end
    end

    // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge pclk) begin
        if (!prst_n) begin
            state_q <= IDLE;
            // NOTE: the register file is reset explicitly; it is flop-based, not a RAM macro.
            regs_q  <= '{default: '0};
`ifdef SLAVE_WAIT_EN
            cnt_q   <= 4'd0;
`endif
        end else begin
            state_q <= state_d;
            regs_q  <= regs_d;
`ifdef SLAVE_WAIT_EN
            cnt_q   <= cnt_d;
`endif
        end
    end

endmodule

// File: tb/tb_apb_slave.sv
// Self-checking bench for apb_slave: directed corner cases plus random transfers against an array model.
// Expected wait count follows SLAVE_WAIT_EN (WAIT_STATES default of 2).
module tb_apb_slave;

    localparam int DEPTH = 16;
`ifdef SLAVE_WAIT_EN
    localparam int W = 2;
`else
    localparam int W = 0;
`endif

    logic       pclk    = 1'b0;
    logic       prst_n  = 1'b0;
    logic       pselx   = 1'b0;
    logic       penable = 1'b0;
    logic       pwrite  = 1'b0;
    logic [7:0] paddr   = 8'h00;
    logic [7:0] pwdata  = 8'h00;
    logic [7:0] prdata;
    logic       pready;
    logic       pslverr;

    int         total = 0;
    int         bad   = 0;
    logic [7:0] model [DEPTH];

    apb_slave dut (
        .pclk    (pclk),
        .prst_n  (prst_n),
        .pselx   (pselx),
        .penable (penable),
        .pwrite  (pwrite),
        .paddr   (paddr),
        .pwdata  (pwdata),
        .prdata  (prdata),
        .pready  (pready),
        .pslverr (pslverr)
    );

    always #5 pclk = ~pclk;

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic next_cycle();
        @(posedge pclk);
        #1;
    endtask

    task automatic drive(input logic s, input logic e, input logic w,
                         input logic [7:0] a, input logic [7:0] d);
        pselx   = s;
        penable = e;
        pwrite  = w;
        paddr   = a;
        pwdata  = d;
    endtask

    task automatic clear_model();
        for (int i = 0; i < DEPTH; i++) model[i] = 8'h00;
    endtask

    // One complete transfer. Setup carries random junk on addr/data/dir, which must not be used.
    task automatic xfer(input logic wr, input logic [7:0] addr, input logic [7:0] data, input bit b2b);
        int         waits;
        bit         done;
        logic       exp_err;
        logic [7:0] exp_rd;

        drive(1'b1, 1'b0, 1'($urandom_range(0, 1)), 8'($urandom), 8'($urandom));
        @(negedge pclk);
        check("setup_pready", pready, 0);
        next_cycle();
        drive(1'b1, 1'b1, wr, addr, data);
        waits = 0;
        done  = 1'b0;
        for (int i = 0; i < 40 && !done; i++) begin
            @(negedge pclk);
            if (pready) begin
                done = 1'b1;
            end else begin
                check("wait_prdata", prdata, 0);
                waits++;
                next_cycle();
            end
        end
        check("completed", done, 1);

        exp_err = (addr >= DEPTH);
        exp_rd  = (!wr && !exp_err) ? model[addr[3:0]] : 8'h00;
        check("wait_count", waits, W);
        check("pslverr", pslverr, exp_err);
        check(wr ? "prdata_on_write" : "prdata_read", prdata, exp_rd);
        if (wr && !exp_err) model[addr[3:0]] = data;
        next_cycle();

        if (!b2b) begin
            drive(1'b0, 1'b0, 1'b0, 8'($urandom), 8'($urandom));
            @(negedge pclk);
            check("idle_pready", pready, 0);
            next_cycle();
        end
    endtask

    initial begin
        clear_model();

        // Outputs must be zero during reset even with an access-phase pattern on the bus.
        drive(1'b1, 1'b1, 1'b0, 8'h03, 8'h00);
        repeat (3) begin
            @(negedge pclk);
            check("rst_pready", pready, 0);
            check("rst_prdata", prdata, 0);
            check("rst_pslverr", pslverr, 0);
        end
        next_cycle();
        prst_n = 1'b1;
        @(negedge pclk);
        check("post_rst_pready", pready, 0);
        next_cycle();
        drive(1'b0, 1'b0, 1'b0, 8'h00, 8'h00);
        next_cycle();

        // Read after reset, write then back-to-back read, out-of-range write.
        xfer(1'b0, 8'h03, 8'h00, 1'b0);
        xfer(1'b1, 8'h05, 8'hA5, 1'b1);
        xfer(1'b0, 8'h05, 8'h00, 1'b0);
        xfer(1'b1, 8'h20, 8'h3C, 1'b0);
        xfer(1'b0, 8'h00, 8'h00, 1'b0);
        xfer(1'b1, 8'hFF, 8'h77, 1'b0);
        xfer(1'b1, 8'h0F, 8'h5E, 1'b0);
        xfer(1'b0, 8'h0F, 8'h00, 1'b0);
        xfer(1'b0, 8'h10, 8'h00, 1'b0);

        // Access phase without setup is ignored and writes nothing.
        drive(1'b1, 1'b1, 1'b1, 8'h04, 8'h77);
        @(negedge pclk);
        check("nosetup_pready", pready, 0);
        check("nosetup_pslverr", pslverr, 0);
        next_cycle();
        drive(1'b0, 1'b0, 1'b0, 8'h00, 8'h00);
        next_cycle();
        xfer(1'b0, 8'h04, 8'h00, 1'b0);

        // Abort: pselx dropped before completion leaves the register untouched.
        xfer(1'b1, 8'h02, 8'h44, 1'b0);
        drive(1'b1, 1'b0, 1'b1, 8'h02, 8'h11);
        next_cycle();
`ifdef SLAVE_WAIT_EN
        drive(1'b1, 1'b1, 1'b1, 8'h02, 8'h11);
        @(negedge pclk);
        check("abort_wait_pready", pready, 0);
        next_cycle();
`endif
        drive(1'b0, 1'b1, 1'b1, 8'h02, 8'h11);
        @(negedge pclk);
        check("abort_pready", pready, 0);
        next_cycle();
        drive(1'b0, 1'b0, 1'b0, 8'h00, 8'h00);
        next_cycle();
        xfer(1'b0, 8'h02, 8'h00, 1'b0);

        // Reset during a write access cycle: no write, all registers cleared.
        xfer(1'b1, 8'h07, 8'h99, 1'b0);
        drive(1'b1, 1'b0, 1'b1, 8'h07, 8'h5A);
        next_cycle();
        drive(1'b1, 1'b1, 1'b1, 8'h07, 8'h5A);
        prst_n = 1'b0;
        @(negedge pclk);
        check("midrst_pready", pready, 0);
        check("midrst_pslverr", pslverr, 0);
        next_cycle();
        prst_n = 1'b1;
        clear_model();
        @(negedge pclk);
        check("midrst_after1_pready", pready, 0);
        next_cycle();
        @(negedge pclk);
        check("midrst_after2_pready", pready, 0);
        next_cycle();
        drive(1'b0, 1'b0, 1'b0, 8'h00, 8'h00);
        next_cycle();
        xfer(1'b0, 8'h07, 8'h00, 1'b0);
        xfer(1'b0, 8'h05, 8'h00, 1'b0);

        // Random traffic, including out-of-range addresses and back-to-back transfers.
        for (int n = 0; n < 150; n++) begin
            logic [7:0] a;
            a = ($urandom_range(0, 3) == 0) ? 8'($urandom_range(16, 255)) : 8'($urandom_range(0, 15));
            xfer(1'($urandom_range(0, 1)), a, 8'($urandom), 1'($urandom_range(0, 1)));
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/apb_slave.md
APB_SLAVE -- requirements
Module: apb_slave

Interface
REQ-001 The block SHALL have parameter ADDR_WIDTH, default 8, giving the paddr width.
REQ-002 The block SHALL have parameter DATA_WIDTH, default 8, giving the pwdata/prdata width.
REQ-003 The block SHALL have parameter DEPTH, default 16, giving the number of registers; legal addresses are 0..DEPTH-1.
REQ-004 The block SHALL have parameter WAIT_STATES, default 2, in range 0..15, counted in access-phase cycles.
REQ-005 The block SHALL have port pclk, input, width 1, the single clock; all logic is on its rising edge.
REQ-006 The block SHALL have port prst_n, input, width 1, a synchronous active-low reset.
REQ-007 The block SHALL have port pselx, input, width 1, the slave select.
REQ-008 The block SHALL have port penable, input, width 1, the access-phase strobe.
REQ-009 The block SHALL have port pwrite, input, width 1: 1 means write, 0 means read.
REQ-010 The block SHALL have port paddr, input, width ADDR_WIDTH, the register address.
REQ-011 The block SHALL have port pwdata, input, width DATA_WIDTH, the write data.
REQ-012 The block SHALL have port prdata, output, width DATA_WIDTH, the read data.
REQ-013 The block SHALL have port pready, output, width 1, the transfer-complete signal.
REQ-014 The block SHALL have port pslverr, output, width 1, the transfer error flag.

Function
REQ-015 The FSM SHALL have states IDLE and ACCESS, plus WAIT when SLAVE_WAIT_EN is defined.
- IDLE goes to ACCESS on pselx=1 & penable=0 (setup phase).
- pselx=1 & penable=1 seen in IDLE (no setup) SHALL be ignored: the block stays in IDLE, pready=0, and no write occurs.
REQ-016 In ACCESS, pready SHALL be 1 combinationally while pselx=1 & penable=1; the cycle with pready=1 is the completing cycle.
REQ-017 After the completing cycle the FSM SHALL return to IDLE. A back-to-back setup in the next cycle starts a new transfer with no dead cycle.
REQ-018 pselx=0 in ACCESS or WAIT SHALL abort the transfer: return to IDLE with no write and no error.
REQ-019 A write SHALL commit pwdata to reg[paddr] at the rising edge that ends the completing cycle, only if paddr<DEPTH.
REQ-020 During a read completing cycle, prdata SHALL equal reg[paddr]; prdata SHALL be 0 in every other cycle.
REQ-021 pslverr SHALL be 1 only in a completing cycle with paddr>=DEPTH. The write is then dropped and prdata=0.
REQ-022 Address comparison SHALL use the full ADDR_WIDTH value of paddr, unsigned, with no truncation or wrap to DEPTH.
REQ-023 paddr, pwrite and pwdata SHALL be sampled in the completing cycle. Their values in the setup cycle are not stored.

Reset
REQ-024 With prst_n=0 at a rising edge, the FSM SHALL go to IDLE, the wait counter SHALL clear to 0, and all DEPTH registers SHALL clear to 0.
REQ-025 While in reset, or in the cycle after reset, prdata, pready and pslverr SHALL all be 0.
REQ-026 Reset asserted mid-transfer SHALL abort the transfer with no write. The master must restart from setup.

Configuration
REQ-027 Macro SLAVE_WAIT_EN SHALL control wait-state insertion.
REQ-028 With SLAVE_WAIT_EN defined:
- The setup phase loads a 4-bit counter with WAIT_STATES.
- ACCESS goes to WAIT if the counter is nonzero.
- In WAIT, pready=0 and the counter decrements once per access cycle.
- The FSM returns to ACCESS when the counter reaches 0.
- The first completing cycle is therefore WAIT_STATES+1 access cycles after setup.
- pslverr and the write take effect only in that completing cycle.
REQ-029 With SLAVE_WAIT_EN undefined, the WAIT state and counter SHALL be absent, WAIT_STATES SHALL be ignored, and every transfer SHALL complete in its first access cycle (zero wait).

Verification
REQ-030 Reset then read of addr 0x03 -> prdata=0x00, pready=1, pslverr=0 in the first access cycle (macro off).
REQ-031 Write 0xA5 to 0x05, then back-to-back read of 0x05 -> read completing cycle shows prdata=0xA5, with no IDLE cycle between transfers.
REQ-032 Write 0x3C to 0x20 (DEPTH=16) -> pslverr=1 and pready=1 in the completing cycle. A subsequent read of 0x00 returns 0x00, and no register changes.
REQ-033 With SLAVE_WAIT_EN and WAIT_STATES=2, read of 0x05 -> pready=0 for 2 access cycles, then pready=1 with prdata=0xA5 on the 3rd.
REQ-034 With SLAVE_WAIT_EN, write 0x11 to 0x02 with pselx dropped during WAIT -> FSM returns to IDLE and a later read of 0x02 returns its prior value.
REQ-035 prst_n=0 during a write's access cycle to 0x07 -> after reset, a read of 0x07 returns 0x00 and pready stays 0 until the next setup.
